// File: rtl/mc_pkg.sv
// Shared encodings for the RV32I multicycle controller, operand muxes and ALU.
// Purely declarative: no logic, no latency.
// MC_CTRL_UPPER_EN adds the LUI/AUIPC states and opcodes to the decode space.
package mc_pkg;

    // FSM states; LUI/AUIPC only exist when upper-immediate support is built in
    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_JAL,
        S_BEQ
`ifdef MC_CTRL_UPPER_EN
        , S_LUI
        , S_AUIPC
`endif
    } state_t;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // ALU operation codes seen by the ALU
    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b0001;
    localparam logic [3:0] ALU_AND    = 4'b0010;
    localparam logic [3:0] ALU_OR     = 4'b0011;
    localparam logic [3:0] ALU_XOR    = 4'b0100;
    localparam logic [3:0] ALU_SLT    = 4'b0101;
    localparam logic [3:0] ALU_SLL    = 4'b0110;
    localparam logic [3:0] ALU_SRL    = 4'b0111;
    localparam logic [3:0] ALU_SRA    = 4'b1000;
    localparam logic [3:0] ALU_SLTU   = 4'b1001;
    localparam logic [3:0] ALU_PASS_B = 4'b1010;

    // Coarse ALU class from the FSM to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_PASSB = 2'b11;

    // Immediate formats
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Result mux selects
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    // ALU operand A selects
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALU operand B selects
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Immediate format is a pure function of the opcode
    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        logic [2:0] f;
        f = IMM_I;
        case (op)
            OP_STORE:  f = IMM_S;
            OP_BRANCH: f = IMM_B;
            OP_JAL:    f = IMM_J;
`ifdef MC_CTRL_UPPER_EN
            OP_LUI,
            OP_AUIPC:  f = IMM_U;
`endif
            default:   f = IMM_I;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Maps the FSM's coarse ALU class plus funct fields onto a concrete ALU operation.
// Latency: purely combinational.
// Backpressure: none.
module mc_alu_decoder
    import mc_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic [6:0] i_opcode,
    output logic [3:0] o_alu_control
);

    // SUB only for register-register ops; ADDI reuses bit 30 as immediate data
    logic w_rtype_sub;
    assign w_rtype_sub = i_opcode[5] & i_funct7b5;

    // Select the ALU operation from the class and the funct fields
    always_comb begin
        o_alu_control = ALU_ADD;
        case (i_alu_op)
            ALUOP_ADD:   o_alu_control = ALU_ADD;
            ALUOP_SUB:   o_alu_control = ALU_SUB;
            ALUOP_PASSB: o_alu_control = ALU_PASS_B;
            default: begin
                case (i_funct3)
                    3'b000:  o_alu_control = w_rtype_sub ? ALU_SUB : ALU_ADD;
                    3'b001:  o_alu_control = ALU_SLL;
                    3'b010:  o_alu_control = ALU_SLT;
                    3'b011:  o_alu_control = ALU_SLTU;
                    3'b100:  o_alu_control = ALU_XOR;
                    3'b101:  o_alu_control = i_funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  o_alu_control = ALU_OR;
                    default: o_alu_control = ALU_AND;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// RV32I multicycle control: Moore FSM driving datapath enables and mux selects.
// Latency: beq/bne 3, R/I-ALU 4, sw 4, jal 4, lw 5, illegal 2 cycles (LUI/AUIPC 4).
// Backpressure: none; advances one datapath step per clock. Macro: MC_CTRL_UPPER_EN.
module mc_control_fsm
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] imm_src,
    output logic [3:0] alu_control,
    output logic       illegal
);

    state_t     r_state;
    state_t     w_next;
    logic       w_pc_update;
    logic       w_branch;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_illegal;
    logic       w_taken;
    logic [1:0] w_alu_op;

    // State register; reset drops straight back to FETCH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and Moore outputs per state
    always_comb begin
        w_next      = S_FETCH;
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_illegal   = 1'b0;
        w_alu_op    = ALUOP_ADD;
        adr_src     = 1'b0;
        result_src  = RES_ALUOUT;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RS2;
        case (r_state)
            S_FETCH: begin
                w_ir_write  = 1'b1;
                w_pc_update = 1'b1;
                alu_src_b   = SRCB_FOUR;
                result_src  = RES_ALURES;
                w_next      = S_DECODE;
            end
            S_DECODE: begin
                // Precompute OldPC + imm so branches/jumps find their target in ALUOut
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_LOAD,
                    OP_STORE:  w_next = S_MEMADR;
                    OP_RTYPE:  w_next = S_EXECUTER;
                    OP_ITYPE:  w_next = S_EXECUTEI;
                    OP_JAL:    w_next = S_JAL;
                    OP_BRANCH: begin
                        // Only beq/bne are implemented
                        if (funct3[2:1] == 2'b00) begin
                            w_next = S_BEQ;
                        end else begin
                            w_illegal = 1'b1;
                            w_next    = S_FETCH;
                        end
                    end
`ifdef MC_CTRL_UPPER_EN
                    OP_LUI:    w_next = S_LUI;
                    OP_AUIPC:  w_next = S_AUIPC;
`endif
                    default: begin
                        w_illegal = 1'b1;
                        w_next    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                w_next    = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                w_next  = S_MEMWB;
            end
            S_MEMWB: begin
                result_src  = RES_RDATA;
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                w_mem_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_EXECUTER: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                w_alu_op  = ALUOP_FUNCT;
                w_next    = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                w_alu_op  = ALUOP_FUNCT;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_JAL: begin
                // PC takes the target from ALUOut while the ALU forms OldPC + 4 for rd
                alu_src_a   = SRCA_OLDPC;
                alu_src_b   = SRCB_FOUR;
                w_pc_update = 1'b1;
                w_next      = S_ALUWB;
            end
            S_BEQ: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                w_alu_op  = ALUOP_SUB;
                w_branch  = 1'b1;
                w_next    = S_FETCH;
            end
`ifdef MC_CTRL_UPPER_EN
            S_LUI: begin
                alu_src_b = SRCB_IMM;
                w_alu_op  = ALUOP_PASSB;
                w_next    = S_ALUWB;
            end
            S_AUIPC: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                w_next    = S_ALUWB;
            end
`endif
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // bne is the only branch with funct3[0] set
    assign w_taken = funct3[0] ? ~zero : zero;

    // Write enables are held off for as long as reset is asserted
    assign pc_write  = ~reset & (w_pc_update | (w_branch & w_taken));
    assign ir_write  = ~reset & w_ir_write;
    assign mem_write = ~reset & w_mem_write;
    assign reg_write = ~reset & w_reg_write;
    assign illegal   = ~reset & w_illegal;
    assign imm_src   = imm_src_of(opcode);

    mc_alu_decoder u_alu_dec (
        .i_alu_op      (w_alu_op),
        .i_funct3      (funct3),
        .i_funct7b5    (funct7b5),
        .i_opcode      (opcode),
        .o_alu_control (alu_control)
    );

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multicycle control unit for the RV32I datapath. Decodes the instruction register and walks a Moore state machine, one datapath step per clock. Generates the write enables, the ALU operand-select codes that feed the operand multiplexers, the result select, the immediate format and the ALU operation. Sits directly upstream of the ALU-source muxes and the ALU.

## Interface
Parameters: none.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; forces state to FETCH
- opcode  in  7  instr[6:0] from instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag, from the current cycle's ALU result
- pc_write  out  1  PC load enable = pc_update | (branch & taken)
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  out  1  data memory write
- ir_write  out  1  instruction register / OldPC load
- reg_write  out  1  register file write
- result_src  out  2  00 ALUOut, 01 read data, 10 ALU result
- alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1 data
- alu_src_b  out  2  00 rs2 data, 01 immediate, 10 constant 4
- imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U (from opcode, combinational)
- alu_control  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLL, 0111 SRL, 1000 SRA, 1001 SLTU, 1010 PASS_B
- illegal  out  1  one-cycle pulse in DECODE on unsupported instruction

## Operation
- States and Moore outputs (unlisted write enables 0, unlisted selects 00, ALU ADD):
- FETCH: adr_src 0, ir_write 1, alu_src_a 00, alu_src_b 10, result_src 10, pc_update 1 -> DECODE.
- DECODE: alu_src_a 01, alu_src_b 01 (branch/jump target into ALUOut). lw/sw -> MEMADR; R -> EXECUTER; I-ALU -> EXECUTEI; jal -> JAL; branch -> BEQ; else illegal=1 -> FETCH.
- MEMADR: alu_src_a 10, alu_src_b 01. lw -> MEMREAD; sw -> MEMWRITE.
- MEMREAD: result_src 00, adr_src 1 -> MEMWB. MEMWB: result_src 01, reg_write 1 -> FETCH.
- MEMWRITE: result_src 00, adr_src 1, mem_write 1 -> FETCH.
- EXECUTER: alu_src_a 10, alu_src_b 00, alu_op 10 -> ALUWB. EXECUTEI: alu_src_a 10, alu_src_b 01, alu_op 10 -> ALUWB.
- ALUWB: result_src 00, reg_write 1 -> FETCH.
- JAL: alu_src_a 01, alu_src_b 10, result_src 00, pc_update 1 -> ALUWB.
- BEQ: alu_src_a 10, alu_src_b 00, alu_op 01, result_src 00, branch 1 -> FETCH. taken = zero for funct3 000, ~zero for 001; other funct3 detected in DECODE as illegal.
- ALU decode: alu_op 00 ADD; 01 SUB; 10 by funct3: 000 ADD (SUB if R-type and funct7b5), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA by funct7b5, 110 OR, 111 AND. funct7b5 ignored for I-type ADDI.
- Supported opcodes: 0000011, 0100011, 0110011, 0010011, 1101111, 1100011 (+ upper ops under macro).

## Timing
- State register updates on rising clk; reset asynchronous, state = FETCH immediately.
- While reset is high, pc_write, ir_write, mem_write and reg_write are forced 0; selects show FETCH values; illegal = 0.
- Instruction latency in cycles: beq/bne 3, R/I-ALU 4, sw 4, jal 4, lw 5, illegal 2.
- pc_write in BEQ depends combinationally on zero in the same cycle; all other outputs depend on state and opcode/funct only.
- opcode/funct inputs valid from DECODE onward; ignored in FETCH.
- Reset mid-instruction abandons it; no write enable asserted after reset release until its own state is reached.

## Configuration
- MC_CTRL_UPPER_EN defined: LUI (0110111) -> state LUI: alu_src_b 01, alu_control PASS_B -> ALUWB; AUIPC (0010111) -> state AUIPC: alu_src_a 01, alu_src_b 01, ADD -> ALUWB; imm_src 100. Both 4 cycles.
- Undefined: both opcodes are illegal (pulse, back to FETCH), no LUI/AUIPC states exist.

## Structure
- Shared package mc_pkg: state enum, opcode constants, alu_control, imm_src, result_src and ALU-source select encodings (shared with the operand muxes and ALU).
- Sub-module mc_alu_decoder: combinational alu_op/funct3/funct7b5/opcode -> alu_control. Main module holds FSM, next-state and output logic.

## Test plan
- Reset held, then released with opcode 0110011, funct3 000, funct7b5 1 -> FETCH, DECODE, EXECUTER (alu_control 0001), ALUWB reg_write 1, FETCH at cycle 5.
- lw (0000011) -> 5-cycle sequence; MEMREAD adr_src 1; MEMWB result_src 01, reg_write 1.
- beq with zero=1 -> pc_write 1 in BEQ cycle; zero=0 -> pc_write 0; bne inverts both.
- opcode 1111111 -> illegal pulse for exactly one cycle in DECODE, no write enables, FETCH next.
- Assert reset during MEMWRITE -> mem_write drops immediately, state FETCH on release.
- With MC_CTRL_UPPER_EN: LUI -> alu_control 1010, alu_src_b 01, reg_write in cycle 4; without it LUI -> illegal pulse.
